// File: rtl/train_led_pkg.sv
// Shared TrainLED protocol constants, transmitter state type and the cell waveform rule.
package train_led_pkg;

  localparam int TL_HI_CLKS       = 4;
  localparam int TL_DATA_CLKS     = 4;
  localparam int TL_LO_CLKS       = 4;
  localparam int TL_CELL_CLKS     = TL_HI_CLKS + TL_DATA_CLKS + TL_LO_CLKS;
  localparam int TL_SAMPLE_POS    = 6;
  localparam int TL_RX_IDLE_RESET = 96;
  localparam int TL_PW_BITS       = 4;

  typedef enum logic [1:0] {
    IDLE,
    CELL,
    GAP
  } tl_tx_state_t;

  // Line level at cell position cc: forced high, then the data bit, then forced low.
  function automatic logic tl_cell_level(input int unsigned cc, input int unsigned hi_clks,
                                         input int unsigned data_clks, input logic data_bit);
    if (cc < hi_clks) return 1'b1;
    if (cc < hi_clks + data_clks) return data_bit;
    return 1'b0;
  endfunction

endpackage

// File: rtl/train_led_bit_cell.sv
// Generates back-to-back pulse-width cells while go is high; dout is registered.
module train_led_bit_cell
  import train_led_pkg::*;
#(
  parameter int HI_CLKS   = TL_HI_CLKS,
  parameter int DATA_CLKS = TL_DATA_CLKS,
  parameter int LO_CLKS   = TL_LO_CLKS
) (
  input  logic clk,
  input  logic rst,
  input  logic go,
  input  logic data_bit,
  output logic dout,
  output logic last
);

  localparam int CELL_CLKS = HI_CLKS + DATA_CLKS + LO_CLKS;
  localparam int CC_W      = $clog2(CELL_CLKS);

  logic [CC_W-1:0] cc_reg;
  logic            dout_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cc_reg   <= '0;
      dout_reg <= 1'b0;
    end else if (go) begin
      dout_reg <= tl_cell_level(32'(cc_reg), 32'(HI_CLKS), 32'(DATA_CLKS), data_bit);
      cc_reg   <= (cc_reg == CC_W'(CELL_CLKS - 1)) ? '0 : cc_reg + 1'b1;
    end else begin
      cc_reg   <= '0;
      dout_reg <= 1'b0;
    end
  end

  assign dout = dout_reg;
  // Seen by the top on the final clock of a cell so the next bit is ready at cc=0.
  assign last = go && (cc_reg == CC_W'(CELL_CLKS - 1));

endmodule

// File: rtl/train_led_driver.sv
// TrainLED chain master: latches one frame, serialises it MSB first, then holds the reset gap.
module train_led_driver
  import train_led_pkg::*;
#(
  parameter int NODES      = 4,
  parameter int PW_BITS    = TL_PW_BITS,
  parameter int HI_CLKS    = TL_HI_CLKS,
  parameter int DATA_CLKS  = TL_DATA_CLKS,
  parameter int LO_CLKS    = TL_LO_CLKS,
  parameter int RESET_CLKS = 100
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NODES*PW_BITS-1:0] frame,
  output logic                     busy,
  output logic                     done,
  output logic                     dout
);

  localparam int FRAME_BITS = NODES * PW_BITS;
  localparam int IDX_W      = $clog2(FRAME_BITS + 1);
  localparam int GAP_W      = $clog2(RESET_CLKS + 1);

  if (NODES < 1 || LO_CLKS < 2 || HI_CLKS < 2 || RESET_CLKS < 99) begin : g_param_check
    $error("train_led_driver: illegal parameters (NODES>=1, HI_CLKS>=2, LO_CLKS>=2, RESET_CLKS>=99)");
  end

  tl_tx_state_t          state_reg;
  logic [FRAME_BITS-1:0] shreg_reg;
  logic [IDX_W-1:0]      bit_idx_reg;
  logic [GAP_W-1:0]      gap_cnt_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  cell_last;

  train_led_bit_cell #(
    .HI_CLKS  (HI_CLKS),
    .DATA_CLKS(DATA_CLKS),
    .LO_CLKS  (LO_CLKS)
  ) u_bit_cell (
    .clk     (clk),
    .rst     (rst),
    .go      (state_reg == CELL),
    .data_bit(shreg_reg[FRAME_BITS-1]),
    .dout    (dout),
    .last    (cell_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      shreg_reg   <= '0;
      bit_idx_reg <= '0;
      gap_cnt_reg <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            shreg_reg   <= frame;
            bit_idx_reg <= '0;
            gap_cnt_reg <= '0;
            busy_reg    <= 1'b1;
            state_reg   <= CELL;
          end
        end
        CELL: begin
          if (cell_last) begin
            shreg_reg   <= shreg_reg << 1;
            bit_idx_reg <= bit_idx_reg + 1'b1;
            if (bit_idx_reg == IDX_W'(FRAME_BITS - 1)) begin
              gap_cnt_reg <= '0;
              state_reg   <= GAP;
            end
          end
        end
        GAP: begin
          gap_cnt_reg <= gap_cnt_reg + 1'b1;
          // done is raised one edge early so it is high during the last gap cycle,
          // while the FSM is still in GAP and a coincident start is ignored.
          if (gap_cnt_reg == GAP_W'(RESET_CLKS - 2)) done_reg <= 1'b1;
          if (gap_cnt_reg == GAP_W'(RESET_CLKS - 1)) begin
            gap_cnt_reg <= '0;
            bit_idx_reg <= '0;
            busy_reg    <= 1'b0;
            state_reg   <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;

endmodule
